// File: rtl/round_key_store.sv
// round_key_store: holds the expanded round keys written by key expansion and
// streams them to the cipher datapath in forward or reverse round order.
module round_key_store #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_wr_data,
  input  logic [3:0]       key_wr_addr,
  input  logic             key_loaded,
  input  logic             start,
  input  logic             decrypt,
  input  logic             rk_ready,
  output logic             rk_valid,
  output logic [KEY_W-1:0] rk_data,
  output logic [3:0]       rk_round,
  output logic             rk_last,
  output logic             keys_ready,
  output logic             busy,
  output logic             err
);
  localparam logic [3:0] MAX_ADDR = 4'(NUM_KEYS);
  localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;

  logic [KEY_W-1:0]    mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] vbits;
  logic                loaded;
  logic                dir_rev;

  logic                wr_hit;
  logic                wr_en;
  logic [3:0]          wr_slot;
  logic                xfer;
  logic [3:0]          first_idx;
  logic [3:0]          next_idx;

  assign wr_hit    = (key_wr_addr != 4'd0) && (key_wr_addr <= MAX_ADDR);
  assign wr_en     = wr_hit && (state == IDLE);
  assign wr_slot   = key_wr_addr - 4'd1;
  assign xfer      = rk_valid && rk_ready;
  assign first_idx = decrypt ? LAST_IDX : 4'd0;
  assign next_idx  = dir_rev ? (rk_round - 4'd1) : (rk_round + 4'd1);

  // Key storage has no reset so it maps onto plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_slot] <= key_wr_data;
  end

  // Writing slot 1 marks the start of a new schedule and invalidates the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbits      <= '0;
      loaded     <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      keys_ready <= loaded & (&vbits);
      if (wr_en) begin
        if (key_wr_addr == 4'd1) begin
          vbits  <= {{(NUM_KEYS-1){1'b0}}, 1'b1};
          loaded <= 1'b0;
        end else begin
          vbits[wr_slot] <= 1'b1;
        end
      end
      if (key_loaded && (state == IDLE)) loaded <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dir_rev  <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (keys_ready) begin
              state    <= STREAM;
              dir_rev  <= decrypt;
              rk_valid <= 1'b1;
              busy     <= 1'b1;
              rk_round <= first_idx;
              rk_data  <= mem[first_idx];
              rk_last  <= (LAST_IDX == 4'd0);
            end else begin
              err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (wr_hit) err <= 1'b1;
          // Index only moves on a handshake, so the beat holds while stalled.
          if (xfer) begin
            if (rk_last) begin
              state    <= IDLE;
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              rk_last  <= 1'b0;
            end else begin
              rk_round <= next_idx;
              rk_data  <= mem[next_idx];
              rk_last  <= dir_rev ? (next_idx == 4'd0) : (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: directed stimulus with a queue-based reference model of
// the key store checked every cycle, plus hand-computed literal expectations.
module tb_round_key_store;
  logic         clk;
  logic         rst;
  logic [127:0] key_wr_data;
  logic [3:0]   key_wr_addr;
  logic         key_loaded;
  logic         start;
  logic         decrypt;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         keys_ready;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  round_key_store #(.KEY_W(128), .NUM_KEYS(11)) dut (
    .clk(clk), .rst(rst),
    .key_wr_data(key_wr_data), .key_wr_addr(key_wr_addr),
    .key_loaded(key_loaded), .start(start), .decrypt(decrypt),
    .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last), .keys_ready(keys_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] key_of(input int i);
    key_of = {32'hC0DE_0000 + 32'(i), 32'h1111_1111 * 32'(i + 1),
              32'hFFFF_FFFF - 32'(i), 32'(i) << 8};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] addr, input logic [127:0] data,
                                input logic ld, input logic st,
                                input logic dec, input logic rdy);
    @(posedge clk);
    #2;
    key_wr_addr = addr;
    key_wr_data = data;
    key_loaded  = ld;
    start       = st;
    decrypt     = dec;
    rk_ready    = rdy;
  endtask

  // Reference model: key array, presence flags and a queue of rounds still to send.
  logic [127:0] m_mem [11];
  bit           m_vbit [11];
  bit           m_loaded;
  bit           m_kr;
  bit           m_kr_next;
  bit           m_err;
  bit           m_wr_ok;
  int           q[$];
  logic [127:0] m_hold_data;
  logic [3:0]   m_hold_round;

  function automatic bit all_valid();
    all_valid = 1'b1;
    for (int i = 0; i < 11; i++) if (!m_vbit[i]) all_valid = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) m_vbit[i] = 1'b0;
      m_loaded     = 1'b0;
      m_kr         = 1'b0;
      m_err        = 1'b0;
      q.delete();
      m_hold_data  = '0;
      m_hold_round = '0;
    end else begin
      m_kr_next = m_loaded && all_valid();
      m_err     = 1'b0;
      m_wr_ok   = (key_wr_addr >= 4'd1) && (key_wr_addr <= 4'd11);
      if (q.size() != 0) begin
        if (m_wr_ok) m_err = 1'b1;
        if (rk_ready) begin
          m_hold_data  = m_mem[q[0]];
          m_hold_round = 4'(q[0]);
          void'(q.pop_front());
        end
      end else begin
        if (m_wr_ok) begin
          m_mem[key_wr_addr - 4'd1]  = key_wr_data;
          if (key_wr_addr == 4'd1) begin
            for (int i = 1; i < 11; i++) m_vbit[i] = 1'b0;
            m_loaded = 1'b0;
          end
          m_vbit[key_wr_addr - 4'd1] = 1'b1;
        end
        if (key_loaded) m_loaded = 1'b1;
        if (start) begin
          if (m_kr) begin
            for (int i = 0; i < 11; i++) q.push_back(decrypt ? 10 - i : i);
          end else begin
            m_err = 1'b1;
          end
        end
      end
      m_kr = m_kr_next;
    end
  end

  logic         exp_valid;
  logic [3:0]   exp_round;
  logic [127:0] exp_data;
  logic         exp_last;

  always @(negedge clk) begin
    exp_valid = (q.size() != 0);
    if (exp_valid) begin
      exp_round = 4'(q[0]);
      exp_data  = m_mem[q[0]];
    end else begin
      exp_round = m_hold_round;
      exp_data  = m_hold_data;
    end
    exp_last = (q.size() == 1);
    check_output("model rk_valid",   128'(rk_valid),   128'(exp_valid));
    check_output("model rk_round",   128'(rk_round),   128'(exp_round));
    check_output("model rk_data",    rk_data,          exp_data);
    check_output("model rk_last",    128'(rk_last),    128'(exp_last));
    check_output("model busy",       128'(busy),       128'(exp_valid));
    check_output("model err",        128'(err),        128'(m_err));
    check_output("model keys_ready", 128'(keys_ready), 128'(m_kr));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen_r0;
    rst = 1'b1;
    key_wr_addr = '0; key_wr_data = '0; key_loaded = 0;
    start = 0; decrypt = 0; rk_ready = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check_output("reset rk_valid",   128'(rk_valid),   128'd0);
    check_output("reset busy",       128'(busy),       128'd0);
    check_output("reset keys_ready", 128'(keys_ready), 128'd0);
    check_output("reset rk_data",    rk_data,          128'd0);

    // T1: load all keys, then key_loaded
    for (int i = 0; i < 11; i++) apply_stimulus(4'(i + 1), key_of(i), 0, 0, 0, 0);
    apply_stimulus(4'd0, '0, 1, 0, 0, 0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    check_output("T1 keys_ready one cycle", 128'(keys_ready), 128'd0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    check_output("T1 keys_ready two cycles", 128'(keys_ready), 128'd1);

    // T2: forward stream, constant ready
    apply_stimulus(4'd0, '0, 0, 1, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(4'd0, '0, 0, 0, 0, 1);
      if (k == 1) begin
        check_output("T2 first round", 128'(rk_round), 128'd0);
        check_output("T2 K0", rk_data, 128'hC0DE0000_11111111_FFFFFFFF_00000000);
      end
      if (k == 5) check_output("T2 K4", rk_data, 128'hC0DE0004_55555555_FFFFFFFB_00000400);
      if (k == 11) begin
        check_output("T2 K10", rk_data, 128'hC0DE000A_BBBBBBBB_FFFFFFF5_00000A00);
        check_output("T2 last on 10", 128'(rk_last), 128'd1);
      end
      if (k == 12) check_output("T2 busy after", 128'(busy), 128'd0);
    end

    // T3: reverse stream, ready toggling
    apply_stimulus(4'd0, '0, 0, 1, 1, 0);
    seen_r0 = 0;
    for (int j = 0; j < 30; j++) begin
      apply_stimulus(4'd0, '0, 0, 0, 0, (j % 2) == 0);
      if (rk_valid && rk_round == 4'd0 && !seen_r0) begin
        seen_r0 = 1;
        check_output("T3 last on round 0", 128'(rk_last), 128'd1);
      end
    end
    check_output("T3 round 0 reached", 128'(seen_r0), 128'd1);
    check_output("T3 busy after", 128'(busy), 128'd0);

    // T4: reload without key_loaded, start rejected
    for (int i = 0; i < 10; i++) apply_stimulus(4'(i + 1), key_of(i), 0, 0, 0, 0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    check_output("T4 keys_ready dropped", 128'(keys_ready), 128'd0);
    apply_stimulus(4'd0, '0, 0, 1, 0, 1);
    apply_stimulus(4'd0, '0, 0, 0, 0, 1);
    check_output("T4 err pulse", 128'(err), 128'd1);
    check_output("T4 no valid", 128'(rk_valid), 128'd0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 1);
    check_output("T4 err one cycle", 128'(err), 128'd0);
    apply_stimulus(4'd11, key_of(10), 0, 0, 0, 0);
    apply_stimulus(4'd0, '0, 1, 0, 0, 0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    check_output("T4 keys_ready restored", 128'(keys_ready), 128'd1);

    // T5: write during stream is dropped
    apply_stimulus(4'd0, '0, 0, 1, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus((k == 2) ? 4'd5 : 4'd0, 128'hBAD, 0, 0, 0, 1);
      if (k == 3) check_output("T5 err on dropped write", 128'(err), 128'd1);
      if (k == 5) begin
        check_output("T5 round 4", 128'(rk_round), 128'd4);
        check_output("T5 K4 intact", rk_data, 128'hC0DE0004_55555555_FFFFFFFB_00000400);
      end
    end

    // T6: reset mid-stream
    apply_stimulus(4'd0, '0, 0, 1, 0, 1);
    for (int k = 1; k <= 3; k++) apply_stimulus(4'd0, '0, 0, 0, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_output("T6 rk_valid", 128'(rk_valid), 128'd0);
    check_output("T6 busy", 128'(busy), 128'd0);
    check_output("T6 rk_data", rk_data, 128'd0);
    check_output("T6 keys_ready", 128'(keys_ready), 128'd0);
    rst = 1'b0;
    apply_stimulus(4'd0, '0, 0, 1, 0, 1);
    apply_stimulus(4'd0, '0, 0, 0, 0, 1);
    check_output("T6 start err", 128'(err), 128'd1);
    check_output("T6 no valid", 128'(rk_valid), 128'd0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);
    apply_stimulus(4'd0, '0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
